acc_sequencer: RTL and testbench

Multicycle fetch/decode/execute controller for the 16-bit accumulator machine. Owns PC, IR and ACC, drives the single-port main memory (synchronous, 1-cycle read latency) and the combinational ALU, and sequences each instruction through a fixed state machine. Sits between `MainMemory` and `ALU` inside `Computer` and replaces the ad-hoc `Control` stepping.

---
 rtl/acc_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_acc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// acc_sequencer: multicycle fetch/decode/execute controller for the 16-bit accumulator machine.
// Latency: LOAD/ALU/MUL/DIV 4 cycles FETCH-to-retire; STORE, JMP, JZ, LOADI, SHL, SHR, NOP, HALT 3 cycles.
// Backpressure: none; memory is fixed 1-cycle read latency and `start` is ignored while busy.
//
// Ports:
//   clock, reset_n        single clock, synchronous active-low reset
//   start                 leaves IDLE or HALTED on the next edge
//   mem_addr/wdata/we     single-port memory request (read data returns on mem_rdata one cycle later)
//   alu_opcode/operand1/2 combinational ALU request (operand1 = ACC, operand2 = mem_rdata)
//   alu_result            combinational ALU response
//   acc, pc               architectural state
//   busy, halted, retire  status; retire pulses on the last cycle of every instruction
//
// Optional feature: define ACC_SEQ_MULDIV_EN to decode opcode E as MUL and F as DIV.
// Without it, E and F behave as NOP on the 3-cycle path.

module acc_sequencer #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [15:0]           mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [15:0]           mem_rdata,
  output logic [3:0]            alu_opcode,
  output logic [15:0]           alu_operand1,
  output logic [15:0]           alu_operand2,
  input  logic [15:0]           alu_result,
  output logic [15:0]           acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  retire
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXECUTE,
    S_HALTED
  } state_e;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_LOADI = 4'hC;
  localparam logic [3:0] OP_NOP   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_DIV   = 4'hF;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [15:0]           acc_q, acc_d;
  logic                  addr_sel_ir;
  logic                  we_raw;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [3:0]            ir_op;

  assign ir_addr = ir_q[ADDR_WIDTH-1:0];
  assign ir_op   = ir_q[15:12];

  // Opcodes whose operand must be read from memory before EXECUTE.
  function automatic logic needs_operand(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
`ifdef ACC_SEQ_MULDIV_EN
      OP_MUL, OP_DIV: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    addr_sel_ir = 1'b0;
    we_raw      = 1'b0;
    retire      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // mem_rdata holds the word addressed by PC during FETCH.
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = needs_operand(mem_rdata[15:12]) ? S_OPERAND : S_EXECUTE;
      end
      S_OPERAND: begin
        addr_sel_ir = 1'b1;
        if (ir_op == OP_STORE) begin
          we_raw  = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        case (ir_op)
          OP_HALT:  state_d = S_HALTED;
          OP_LOAD:  acc_d = mem_rdata;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: acc_d = alu_result;
`ifdef ACC_SEQ_MULDIV_EN
          OP_MUL:   acc_d = alu_result;
          // Divide by zero saturates instead of trusting the ALU.
          OP_DIV:   acc_d = (mem_rdata == 16'h0000) ? 16'hFFFF : alu_result;
`endif
          OP_LOADI: acc_d = {4'h0, ir_q[11:0]};
          OP_JMP:   pc_d = ir_addr;
          // Tests the registered ACC, i.e. the value before this edge.
          OP_JZ:    if (acc_q == 16'h0000) pc_d = ir_addr;
          default:  ;
        endcase
      end
      S_HALTED: begin
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_opcode = 4'b0000;
    case (ir_op)
      OP_ADD: alu_opcode = 4'b0000;
      OP_SUB: alu_opcode = 4'b0001;
`ifdef ACC_SEQ_MULDIV_EN
      OP_MUL: alu_opcode = 4'b0010;
      OP_DIV: alu_opcode = 4'b0011;
`endif
      OP_SHL: alu_opcode = 4'b0100;
      OP_SHR: alu_opcode = 4'b0101;
      OP_AND: alu_opcode = 4'b1000;
      OP_OR:  alu_opcode = 4'b1001;
      OP_XOR: alu_opcode = 4'b1010;
      default: alu_opcode = 4'b0000;
    endcase
  end

  assign mem_addr     = addr_sel_ir ? 16'(ir_addr) : 16'(pc_q);
  assign mem_wdata    = acc_q;
  // A reset landing on a STORE's OPERAND cycle must not corrupt memory.
  assign mem_we       = we_raw & reset_n;
  assign alu_operand1 = acc_q;
  assign alu_operand2 = mem_rdata;
  assign acc          = acc_q;
  assign pc           = pc_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_OPERAND) || (state_q == S_EXECUTE);
  assign halted       = (state_q == S_HALTED);

endmodule

// File: tb/tb_acc_sequencer.sv
module tb_acc_sequencer;

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instance 0: RESET_PC = 0. Instance 1: RESET_PC = FFF (wrap test).
  logic        rst0_n, start0, rst1_n, start1;
  logic [15:0] addr0, wdata0, rdata0, op1_0, op2_0, res0, acc0;
  logic [15:0] addr1, wdata1, rdata1, op1_1, op2_1, res1, acc1;
  logic [3:0]  aop0, aop1;
  logic [11:0] pc0, pc1;
  logic        we0, busy0, halted0, ret0;
  logic        we1, busy1, halted1, ret1;

  logic [15:0] mem0 [0:4095];
  logic [15:0] mem1 [0:4095];
  logic        ld_vld, ld_sel;
  logic [11:0] ld_a;
  logic [15:0] ld_d;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a * b;
      4'b0011: r = (b == 16'h0000) ? 16'h1234 : a / b;
      4'b0100: r = a << 1;
      4'b0101: r = a >> 1;
      4'b1000: r = a & b;
      4'b1001: r = a | b;
      4'b1010: r = a ^ b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  assign res0 = alu_f(aop0, op1_0, op2_0);
  assign res1 = alu_f(aop1, op1_1, op2_1);

  always @(posedge clock) begin
    if (ld_vld && !ld_sel) mem0[ld_a] <= ld_d;
    else if (we0)          mem0[addr0[11:0]] <= wdata0;
    rdata0 <= mem0[addr0[11:0]];
  end

  always @(posedge clock) begin
    if (ld_vld && ld_sel) mem1[ld_a] <= ld_d;
    else if (we1)         mem1[addr1[11:0]] <= wdata1;
    rdata1 <= mem1[addr1[11:0]];
  end

  acc_sequencer #(.ADDR_WIDTH(12), .RESET_PC(12'h000)) dut0 (
    .clock(clock), .reset_n(rst0_n), .start(start0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0), .mem_rdata(rdata0),
    .alu_opcode(aop0), .alu_operand1(op1_0), .alu_operand2(op2_0), .alu_result(res0),
    .acc(acc0), .pc(pc0), .busy(busy0), .halted(halted0), .retire(ret0)
  );

  acc_sequencer #(.ADDR_WIDTH(12), .RESET_PC(12'hFFF)) dut1 (
    .clock(clock), .reset_n(rst1_n), .start(start1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1), .mem_rdata(rdata1),
    .alu_opcode(aop1), .alu_operand1(op1_1), .alu_operand2(op2_1), .alu_result(res1),
    .acc(acc1), .pc(pc1), .busy(busy1), .halted(halted1), .retire(ret1)
  );

  // Observation mux: sel picks which instance the shared tasks look at.
  logic        sel;
  logic        obs_ret, obs_busy, obs_halted, obs_we;
  logic [15:0] obs_addr, obs_acc;
  logic [11:0] obs_pc;
  assign obs_ret    = sel ? ret1    : ret0;
  assign obs_busy   = sel ? busy1   : busy0;
  assign obs_halted = sel ? halted1 : halted0;
  assign obs_we     = sel ? we1     : we0;
  assign obs_addr   = sel ? addr1   : addr0;
  assign obs_acc    = sel ? acc1    : acc0;
  assign obs_pc     = sel ? pc1     : pc0;

  // Scoreboard: one entry per expected retire.
  typedef struct {
    logic [15:0] acc;
    logic [15:0] nxt;
    logic        halt;
  } exp_t;
  exp_t sbq[$];

  int ncomp, nfail;
  int nret, halt_at;
  int rcyc[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic s, input logic [11:0] a, input logic [15:0] d);
    ld_sel = s;
    ld_a   = a;
    ld_d   = d;
    ld_vld = 1'b1;
    tick();
    ld_vld = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] n, input logic h);
    exp_t e;
    e.acc  = a;
    e.nxt  = n;
    e.halt = h;
    sbq.push_back(e);
  endtask

  // Bounded run: pops one expectation per retire and checks the state after that edge.
  task automatic run(input string tag, input int n);
    int   pend;
    exp_t e;
    pend    = 0;
    nret    = 0;
    halt_at = -1;
    rcyc.delete();
    for (int c = 1; c <= n; c++) begin
      if (obs_ret) begin
        pend = 1;
        nret++;
        rcyc.push_back(c);
      end
      tick();
      if (pend != 0) begin
        chk({tag, "_sb_has_entry"}, 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk({tag, "_acc"}, obs_acc, e.acc);
          if (e.halt) chk({tag, "_halted"}, obs_halted, 1);
          else        chk({tag, "_fetch_addr"}, obs_addr, e.nxt);
        end
        pend = 0;
      end
      if (obs_halted && halt_at < 0) halt_at = c;
    end
  endtask

  task automatic pulse_start(input logic s);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    ncomp = 0; nfail = 0;
    sel = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    ld_vld = 1'b0; ld_sel = 1'b0; ld_a = '0; ld_d = '0;

    // Reset held two cycles, then released.
    tick(); tick();
    rst0_n = 1'b1;
    #1;
    chk("rst_pc", pc0, 12'h000);
    chk("rst_acc", acc0, 16'h0000);
    chk("rst_busy", busy0, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_we", we0, 0);
    chk("rst_retire", ret0, 0);
    tick(); tick(); tick();
    chk("idle_busy", busy0, 0);
    chk("idle_addr", addr0, 16'h0000);

    // Basic program: LOADI 5; ADD [010]; STORE [011]; HALT.
    poke(0, 12'h000, 16'hC005);
    poke(0, 12'h001, 16'h3010);
    poke(0, 12'h002, 16'h2011);
    poke(0, 12'h003, 16'h0000);
    poke(0, 12'h010, 16'h0007);
    poke(0, 12'h011, 16'h0000);
    push(16'h0005, 16'h0001, 0);
    push(16'h000C, 16'h0002, 0);
    push(16'h000C, 16'h0003, 0);
    push(16'h000C, 16'h0000, 1);
    pulse_start(0);
    run("prog", 16);
    chk("prog_halt_cycle", halt_at, 13);
    chk("prog_retires", nret, 4);
    chk("prog_m11", mem0[12'h011], 16'h000C);
    chk("prog_pc", pc0, 12'h004);
    chk("prog_busy", busy0, 0);

    // JZ taken with ACC=0, then not taken with ACC=1.
    poke(0, 12'h004, 16'hC000);
    poke(0, 12'h005, 16'h9020);
    poke(0, 12'h020, 16'hC001);
    poke(0, 12'h021, 16'h9020);
    poke(0, 12'h022, 16'h0000);
    push(16'h0000, 16'h0005, 0);
    push(16'h0000, 16'h0020, 0);
    push(16'h0001, 16'h0021, 0);
    push(16'h0001, 16'h0022, 0);
    push(16'h0001, 16'h0000, 1);
    pulse_start(0);
    run("jz", 20);
    chk("jz_retires", nret, 5);
    chk("jz_pc", pc0, 12'h023);

    // MUL / DIV (or NOP when the feature is disabled).
    poke(0, 12'h023, 16'hC003);
    poke(0, 12'h024, 16'hE010);
    poke(0, 12'h010, 16'h0005);
    poke(0, 12'h025, 16'hF040);
    poke(0, 12'h040, 16'h0000);
    poke(0, 12'h026, 16'h0000);
    push(16'h0003, 16'h0024, 0);
`ifdef ACC_SEQ_MULDIV_EN
    push(16'h000F, 16'h0025, 0);
    push(16'hFFFF, 16'h0026, 0);
    push(16'hFFFF, 16'h0000, 1);
`else
    push(16'h0003, 16'h0025, 0);
    push(16'h0003, 16'h0026, 0);
    push(16'h0003, 16'h0000, 1);
`endif
    pulse_start(0);
    run("md", 20);
    chk("md_retires", nret, 4);
    if (rcyc.size() == 4) begin
`ifdef ACC_SEQ_MULDIV_EN
      chk("md_mul_cycles", rcyc[1] - rcyc[0], 4);
      chk("md_div_cycles", rcyc[2] - rcyc[1], 4);
`else
      chk("md_e_cycles", rcyc[1] - rcyc[0], 3);
      chk("md_f_cycles", rcyc[2] - rcyc[1], 3);
`endif
    end
    chk("md_pc", pc0, 12'h027);

    // Reset landing on the OPERAND cycle of STORE 2011.
    poke(0, 12'h027, 16'h2011);
    poke(0, 12'h011, 16'h5555);
    pulse_start(0);
    tick(); tick();
    chk("rs_operand_addr", addr0, 16'h0011);
    chk("rs_we_before", we0, 1);
    rst0_n = 1'b0;
    #1;
    chk("rs_we_gated", we0, 0);
    tick();
    chk("rs_m11", mem0[12'h011], 16'h5555);
    chk("rs_busy", busy0, 0);
    chk("rs_halted", halted0, 0);
    chk("rs_pc", pc0, 12'h000);
    chk("rs_acc", acc0, 16'h0000);
    rst0_n = 1'b1;

    // PC wrap on the RESET_PC = FFF instance.
    sel = 1'b1;
    poke(1, 12'hFFF, 16'hC001);
    poke(1, 12'h000, 16'h0000);
    rst1_n = 1'b1;
    #1;
    chk("wr_rst_pc", pc1, 12'hFFF);
    chk("wr_idle_addr", addr1, 16'h0FFF);
    push(16'h0001, 16'h0000, 0);
    push(16'h0001, 16'h0000, 1);
    pulse_start(1);
    run("wrap", 10);
    chk("wr_retires", nret, 2);
    chk("wr_pc", pc1, 12'h001);

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
